// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the interrupt priority controller.
package int_ctrl_pkg;

  localparam int unsigned DEFAULT_NUM_SOURCES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_priority_encoder.sv
// Lowest-index-first priority encoder: index 0 wins over all others.
module int_priority_encoder #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  logic found_s;

  // Scan upward; the first set bit found is kept.
  always_comb begin
    idx     = '0;
    found_s = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      idx     = (req[i] && !found_s) ? ID_W'(i) : idx;
      found_s = found_s | req[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/int_priority_controller.sv
// Interrupt controller: pending/overrun capture per source and a single-level
// IDLE -> REQUEST -> SERVICE handshake with the CPU.
module int_priority_controller
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int unsigned ID_W        = $clog2(NUM_SOURCES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] int_req,
  input  logic [NUM_SOURCES-1:0] int_mask,
  input  logic                   gie,
  output logic                   irq,
  output logic [ID_W-1:0]        irq_id,
  input  logic                   irq_ack,
  input  logic                   irq_done,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] overrun,
  input  logic [NUM_SOURCES-1:0] clr_overrun,
  output logic                   in_service
);

  state_e                 state_q, state_d;
  logic                   irq_q, irq_d;
  logic [ID_W-1:0]        irq_id_q, irq_id_d;
  logic                   in_service_q, in_service_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] overrun_q, overrun_d;
  logic [NUM_SOURCES-1:0] ack_clr_s;
  logic                   enc_any_s;
  logic [ID_W-1:0]        enc_idx_s;

  int_priority_encoder #(
    .N    (NUM_SOURCES),
    .ID_W (ID_W)
  ) u_enc (
    .req (pending_q & int_mask),
    .any (enc_any_s),
    .idx (enc_idx_s)
  );

  // Accepted request clears its own pending bit; a new pulse on the same edge wins.
  always_comb begin
    ack_clr_s = '0;
    if (state_q == ST_REQUEST && irq_ack) begin
      ack_clr_s = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << irq_id_q;
    end else begin
      ack_clr_s = '0;
    end
    pending_d = (pending_q & ~ack_clr_s) | int_req;
    overrun_d = (overrun_q & ~clr_overrun) | (int_req & pending_q & ~ack_clr_s);
  end

  // Handshake FSM next state; irq_id is latched only on entry to REQUEST.
  always_comb begin
    state_d      = state_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    case (state_q)
      ST_IDLE: begin
        if (gie && enc_any_s) begin
          state_d  = ST_REQUEST;
          irq_d    = 1'b1;
          irq_id_d = enc_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (irq_ack) begin
          state_d      = ST_SERVICE;
          irq_d        = 1'b0;
          in_service_d = 1'b1;
        end else begin
          state_d = ST_REQUEST;
        end
      end
      ST_SERVICE: begin
        if (irq_done) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        irq_d        = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign irq        = irq_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_int_priority_controller.sv
// Bench for int_priority_controller: per-cycle reference model comparison plus
// directed scenarios with literal expectations.
module tb_int_priority_controller;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] int_req, int_mask, clr_overrun;
  logic          gie, irq_ack, irq_done;
  logic          irq, in_service;
  logic [1:0]    irq_id;
  logic [NS-1:0] pending, overrun;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int_priority_controller #(.NUM_SOURCES(NS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_req     (int_req),
    .int_mask    (int_mask),
    .gie         (gie),
    .irq         (irq),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack),
    .irq_done    (irq_done),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .in_service  (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: phase 0 = waiting, 1 = request raised, 2 = CPU servicing.
  int       m_phase;
  int       m_id;
  int       ack_src;
  bit [NS-1:0] m_pend, m_ovr;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_id = 0; m_pend = '0; m_ovr = '0;
    end else begin
      ack_src = (m_phase == 1 && irq_ack) ? m_id : -1;
      if (m_phase == 0) begin
        if (gie) begin
          for (int i = NS - 1; i >= 0; i--)
            if (m_pend[i] && int_mask[i]) begin m_id = i; m_phase = 1; end
        end
      end else if (m_phase == 1) begin
        if (irq_ack) m_phase = 2;
      end else begin
        if (irq_done) m_phase = 0;
      end
      for (int i = 0; i < NS; i++) begin
        if (int_req[i]) begin
          if (m_pend[i] && i != ack_src) m_ovr[i] = 1'b1;
          else if (clr_overrun[i]) m_ovr[i] = 1'b0;
          m_pend[i] = 1'b1;
        end else begin
          if (i == ack_src) m_pend[i] = 1'b0;
          if (clr_overrun[i]) m_ovr[i] = 1'b0;
        end
      end
    end
  end

  // Every cycle after reset, DUT outputs must match the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("m_irq", 32'(irq), 32'(m_phase == 1));
      check("m_in_service", 32'(in_service), 32'(m_phase == 2));
      check("m_pending", 32'(pending), 32'(m_pend));
      check("m_overrun", 32'(overrun), 32'(m_ovr));
      if (m_phase == 1) check("m_irq_id", 32'(irq_id), 32'(m_id));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; int_req = '0; int_mask = 4'hF; clr_overrun = '0;
    gie = 1'b1; irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_insvc", 32'(in_service), 32'd0);
    rst_n = 1'b1; chk_en = 1'b1;
    tick();

    // Single pulse on source 2
    int_req = 4'b0100; tick(); int_req = '0;
    check("sp_pend", 32'(pending), 32'h4);
    check("sp_irq_early", 32'(irq), 32'd0);
    tick();
    check("sp_irq", 32'(irq), 32'd1);
    check("sp_id", 32'(irq_id), 32'd2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("sp_ack_pend", 32'(pending), 32'h0);
    check("sp_ack_insvc", 32'(in_service), 32'd1);
    check("sp_ack_irq", 32'(irq), 32'd0);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("sp_done_insvc", 32'(in_service), 32'd0);
    tick();
    check("sp_idle_irq", 32'(irq), 32'd0);

    // Priority: sources 1 and 3 together; request held through gie/mask drop
    int_req = 4'b1010; tick(); int_req = '0; tick();
    check("pr_id1", 32'(irq_id), 32'd1);
    gie = 1'b0; int_mask = 4'h0; tick();
    check("pr_hold_irq", 32'(irq), 32'd1);
    check("pr_hold_id", 32'(irq_id), 32'd1);
    gie = 1'b1; int_mask = 4'hF;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("pr_pend", 32'(pending), 32'h8);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("pr_idle_irq", 32'(irq), 32'd0);
    tick();
    check("pr_irq3", 32'(irq), 32'd1);
    check("pr_id3", 32'(irq_id), 32'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;

    // Masking, plus ack/done ignored while idle
    int_mask = 4'hE; int_req = 4'b0001; tick(); int_req = '0;
    check("mk_pend", 32'(pending), 32'h1);
    irq_ack = 1'b1; irq_done = 1'b1; tick(); irq_ack = 1'b0; irq_done = 1'b0;
    check("mk_ack_ignored", 32'(pending), 32'h1);
    check("mk_irq", 32'(irq), 32'd0);
    int_mask = 4'hF; tick();
    check("mk_irq_on", 32'(irq), 32'd1);
    check("mk_id", 32'(irq_id), 32'd0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;

    // Overrun capture, clear, and set-vs-ack collision on source 3
    gie = 1'b0;
    int_req = 4'b1000; tick(); int_req = '0; tick();
    int_req = 4'b1000; tick(); int_req = '0;
    check("ov_set", 32'(overrun), 32'h8);
    clr_overrun = 4'b1000; tick(); clr_overrun = '0;
    check("ov_clr", 32'(overrun), 32'h0);
    int_req = 4'b1000; clr_overrun = 4'b1000; tick(); int_req = '0; clr_overrun = '0;
    check("ov_set_beats_clr", 32'(overrun), 32'h8);
    clr_overrun = 4'b1000; tick(); clr_overrun = '0;
    gie = 1'b1; tick();
    check("ov_irq_id", 32'(irq_id), 32'd3);
    int_req = 4'b1000; irq_ack = 1'b1; tick(); int_req = '0; irq_ack = 1'b0;
    check("ov_coll_pend", 32'(pending), 32'h8);
    check("ov_coll_ovr", 32'(overrun), 32'h0);
    check("ov_coll_insvc", 32'(in_service), 32'd1);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    tick();
    check("ov_rereq", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;

    // Reset while servicing with two sources pending
    int_req = 4'b0011; tick(); int_req = '0; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_req = 4'b0001; tick(); int_req = '0;
    check("rs_pend_pre", 32'(pending), 32'h3);
    check("rs_insvc_pre", 32'(in_service), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rs_irq", 32'(irq), 32'd0);
    check("rs_id", 32'(irq_id), 32'd0);
    check("rs_pend", 32'(pending), 32'h0);
    check("rs_ovr", 32'(overrun), 32'h0);
    check("rs_insvc", 32'(in_service), 32'd0);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("rs_done_ignored", 32'(in_service), 32'd0);
    tick();
    check("rs_no_irq", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
